pipeline_stall_controller: RTL and testbench

Central hazard and stall sequencer for the 5-stage MIPS pipeline. It watches the IF/ID, ID/EX and EX/MEM stages and drives the PC and every pipeline register. Outputs are enables, flushes and a MEM/WB bubble; MEM/WB has no enable, so it is neutralised by zeroing its control inputs. It resolves load-use hazards, ID-stage branch/jump redirects and multi-cycle data-memory waits, halts the pipeline on a memory timeout, and keeps saturating performance counters.

---
 rtl/pipeline_stall_controller.sv | 115 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard and stall sequencer for a 5-stage MIPS pipeline: load-use bubbles,
// ID-stage redirects, data-memory waits with timeout halt, and saturating counters.
module pipeline_stall_controller #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             MEM_WB_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  // wait_cnt already counts the current stalled cycle, so the last legal value is TIMEOUT-1.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       mem_stall;
  logic       redirect;

  assign load_use  = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                     ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));
  assign mem_stall = mem_req && !mem_ready;
  assign redirect  = branch_taken || jump;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    PC_en         = 1'b1;
    IF_ID_en      = 1'b1;
    ID_EX_en      = 1'b1;
    EX_MEM_en     = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_flush   = 1'b0;
    MEM_WB_bubble = 1'b0;
    halted        = 1'b0;
    if (state == HALT) begin
      PC_en         = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_en      = 1'b0;
      EX_MEM_en     = 1'b0;
      MEM_WB_bubble = 1'b1;
      halted        = 1'b1;
    end else if (mem_stall) begin
      PC_en         = 1'b0;
      IF_ID_en      = 1'b0;
      ID_EX_en      = 1'b0;
      EX_MEM_en     = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (load_use) begin
      // A redirect is dropped here: the branch compared stale operands.
      PC_en       = 1'b0;
      IF_ID_en    = 1'b0;
      ID_EX_flush = 1'b1;
    end else if (redirect) begin
      IF_ID_flush = 1'b1;
    end
  end

  // State moves on the falling edge, in step with the pipeline registers.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!PC_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if ((IF_ID_flush || ID_EX_flush) && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);

      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt == LAST_WAIT) state <= HALT;
            else                       wait_cnt <= wait_cnt + 8'd1;
          end else begin
            // Covers both a normal release and a dropped request (tolerated protocol error).
            state    <= RUN;
            wait_cnt <= 8'd0;
          end
        end
        HALT:    ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed scenarios then random traffic against a
// cycle-level reference model of the stall rules and counters.
module tb_pipeline_stall_controller;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
  logic       branch_taken, jump, mem_req, mem_ready;

  logic        PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_bubble, halted;
  logic [15:0] stall_cycles, flush_count;
  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_if_id_flush, s_id_ex_flush, s_bubble, s_halted;
  logic [3:0]  s_stall_cycles, s_flush_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: halt flag, consecutive stalled-access length, raw event counts.
  bit m_halted;
  int m_consec, m_stall, m_flush;

  pipeline_stall_controller #(.CNT_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .branch_taken(branch_taken), .jump(jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .PC_en(PC_en), .IF_ID_en(IF_ID_en),
    .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en), .IF_ID_flush(IF_ID_flush),
    .ID_EX_flush(ID_EX_flush), .MEM_WB_bubble(MEM_WB_bubble), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_stall_controller #(.CNT_W(4), .TIMEOUT(TO)) dut_sat (
    .clk(clk), .reset(reset), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .branch_taken(branch_taken), .jump(jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .PC_en(s_pc_en), .IF_ID_en(s_if_id_en),
    .ID_EX_en(s_id_ex_en), .EX_MEM_en(s_ex_mem_en), .IF_ID_flush(s_if_id_flush),
    .ID_EX_flush(s_id_ex_flush), .MEM_WB_bubble(s_bubble), .halted(s_halted),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_bubble, halted}.
  function automatic logic [7:0] exp_outs();
    if (m_halted)                                   return 8'b0000_0011;
    if (mem_req && !mem_ready)                      return 8'b0000_0010;
    if (ID_EX_MemRead && ID_EX_Rt != 0 &&
        (ID_EX_Rt == IF_ID_Rs || ID_EX_Rt == IF_ID_Rt)) return 8'b0011_0100;
    if (branch_taken || jump)                       return 8'b1111_1000;
    return 8'b1111_0000;
  endfunction

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_outs"}, 32'({PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_flush, MEM_WB_bubble, halted}), 32'(exp_outs()));
    check({tag, "_stall"}, 32'(stall_cycles), sat(m_stall, 65535));
    check({tag, "_flush"}, 32'(flush_count), sat(m_flush, 65535));
    check({tag, "_sat_stall"}, 32'(s_stall_cycles), sat(m_stall, 15));
    check({tag, "_sat_flush"}, 32'(s_flush_count), sat(m_flush, 15));
  endtask

  task automatic model_update();
    logic [7:0] e;
    e = exp_outs();
    if (!e[7])        m_stall++;
    if (e[3] || e[2]) m_flush++;
    if (!m_halted) begin
      if (mem_req && !mem_ready) begin
        m_consec++;
        if (m_consec == TO) m_halted = 1'b1;
      end else begin
        m_consec = 0;
      end
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic jp, input logic req, input logic rdy);
    ID_EX_MemRead = mr; ID_EX_Rt = ert; IF_ID_Rs = rs; IF_ID_Rt = rt;
    branch_taken = br; jump = jp; mem_req = req; mem_ready = rdy;
  endtask

  // One pipeline cycle: drive after the rising edge, check mid-cycle, model advances on the falling edge.
  task automatic step(input string tag, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic br, input logic jp, input logic req, input logic rdy);
    @(posedge clk);
    set_in(mr, ert, rs, rt, br, jp, req, rdy);
    #1;
    check_all(tag);
    @(negedge clk);
    model_update();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    m_halted = 0; m_consec = 0; m_stall = 0; m_flush = 0;
    #1;
    check_all("reset");
    @(negedge clk);
    #1;
    check_all("reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    m_halted = 0; m_consec = 0; m_stall = 0; m_flush = 0;
    #1;
    check_all("por");
    check("por_pc_en", 32'(PC_en), 1);
    apply_reset();

    // Load-use: lw $t0 followed by a consumer of $t0.
    step("quiet", 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu", 1, 8, 8, 3, 0, 0, 0, 0);
    step("lu_clear", 0, 8, 8, 3, 0, 0, 0, 0);
    #1;
    check("lu_stall_cnt", 32'(stall_cycles), 1);
    check("lu_flush_cnt", 32'(flush_count), 1);

    // $zero never hazards; load-use beats a simultaneous redirect; plain redirects.
    step("zero_reg", 1, 0, 0, 0, 0, 0, 0, 0);
    step("lu_branch", 1, 9, 2, 9, 1, 0, 0, 0);
    step("branch", 0, 9, 2, 9, 1, 0, 0, 0);
    step("jump", 0, 0, 0, 0, 0, 1, 0, 0);
    step("all_three", 1, 9, 9, 0, 1, 1, 1, 0);
    step("release_lu", 1, 9, 9, 0, 1, 1, 1, 1);

    // Three-cycle memory wait, zero-latency release.
    apply_reset();
    repeat (3) step("mem_wait", 0, 0, 0, 0, 0, 0, 1, 0);
    step("mem_release", 0, 0, 0, 0, 0, 0, 1, 1);
    step("after_mem", 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mem_stall_cnt", 32'(stall_cycles), 3);
    check("mem_not_halted", 32'(halted), 0);

    // Reset pulled mid-wait, off the clock edge.
    repeat (3) step("pre_reset_wait", 0, 0, 0, 0, 0, 0, 1, 0);
    apply_reset();
    check("rst_pc_en", 32'(PC_en), 1);
    check("rst_stall_cnt", 32'(stall_cycles), 0);

    // Timeout: halt at the 4th stalled edge, then inputs are ignored.
    repeat (TO) step("to_wait", 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    check("to_halted", 32'(halted), 1);
    repeat (10) step("halt_hold", 1'($urandom), pick_reg(), pick_reg(), pick_reg(),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    #1;
    check("halt_stall_cnt", 32'(stall_cycles), 14);
    repeat (2) step("halt_more", 0, 0, 0, 0, 1, 0, 1, 1);
    #1;
    check("sat_stall_cnt", 32'(s_stall_cycles), 15);
    check("wide_stall_cnt", 32'(stall_cycles), 16);

    // Random traffic, with occasional resets to escape HALT.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      logic req;
      req = ($urandom_range(0, 9) < 3);
      step("rand", 1'($urandom), pick_reg(), pick_reg(), pick_reg(),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), req,
           req ? 1'($urandom) : 1'($urandom_range(0, 1)));
      if (m_halted && $urandom_range(0, 7) == 0) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
